ap_cam_engine: RTL
==================

AP_CAM_ENGINE -- requirements
Module: ap_cam_engine

Interface
REQ-001 Parameter WORD_SIZE, default 8, bits per CAM row.
REQ-002 Parameter CELL_QUANT, default 512, number of rows (any value >= 2, need not be a power of two).
REQ-003 Derived constants: ADDR_W = clog2(CELL_QUANT); CNT_W = clog2(CELL_QUANT+1).
REQ-004 CLK100MHZ  in  1  sole clock, all state updates on its rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 cmd_valid  in  1  command offered.
REQ-007 cmd_ready  out  1  engine can accept a command.
REQ-008 cmd_op  in  3  opcode: NOP, WRITE, READ, SEARCH, AP_WRITE, TAG_CLR, TAG_SET.
REQ-009 cmd_tmode  in  2  SEARCH tag combine: LOAD, AND, OR.
REQ-010 cmd_addr  in  ADDR_W  row address for WRITE/READ.
REQ-011 cmd_data  in  WORD_SIZE  write data for WRITE/AP_WRITE; search key for SEARCH.
REQ-012 cmd_mask  in  WORD_SIZE  per-bit enable: compare mask for SEARCH, bit-write mask for AP_WRITE.
REQ-013 rsp_valid  out  1  one-cycle response pulse.
REQ-014 rsp_err  out  1  address out of range, qualified by rsp_valid.
REQ-015 rsp_data  out  WORD_SIZE  READ result, qualified by rsp_valid.
REQ-016 tags  out  CELL_QUANT  registered tag vector.
REQ-017 hit  out  1  OR of tags.
REQ-018 match_cnt  out  CNT_W  population count of tags.
REQ-019 first_idx  out  ADDR_W  lowest set tag index (macro-dependent).

Function
REQ-020 Handshake: command accepted on a rising edge with cmd_valid && cmd_ready; cmd_ready SHALL be 1 only in IDLE.
REQ-021 FSM: IDLE -(accept)-> EXEC -> RESP -> IDLE; one cycle each in EXEC and RESP; NOP also traverses all states.
REQ-022 Command fields SHALL be registered at acceptance; input changes afterwards SHALL have no effect.
REQ-023 Array and tag updates commit at the EXEC->RESP edge; rsp_valid SHALL be 1 exactly during RESP, i.e. 2 cycles after acceptance.
REQ-024 WRITE: row[cmd_addr] <= cmd_data (full word).
REQ-025 READ: rsp_data = row[cmd_addr] as of the commit edge; rsp_data SHALL be 0 for non-READ responses.
REQ-026 SEARCH: row r matches when ((row[r] ^ key) & mask) == 0; LOAD tags=match, AND tags&=match, OR tags|=match; mask=0 matches every row.
REQ-027 AP_WRITE: for every r with tags[r]=1, row[r] <= (row[r] & ~mask) | (data & mask); tags=0 writes nothing yet still responds.
REQ-028 TAG_CLR sets tags to all-0; TAG_SET sets tags[r]=1 for every r < CELL_QUANT.
REQ-029 cmd_addr >= CELL_QUANT on WRITE/READ: no array change, rsp_data=0, rsp_err=1; rsp_err=0 otherwise.
REQ-030 hit, match_cnt, first_idx are combinational from registered tags; match_cnt = CELL_QUANT when all tags set (no overflow).
REQ-031 Undefined cmd_op encodings SHALL behave as NOP.

Reset
REQ-032 rst low: state IDLE, cmd_ready=1 (while rst high), rsp_valid=0, rsp_err=0, rsp_data=0, tags=0, hit=0, match_cnt=0, first_idx=0, every row=0.
REQ-033 Reset asserted in EXEC before the commit edge SHALL abort: no array or tag change, no response.

Configuration
REQ-034 Macro AP_CAM_PRIO_ENC_EN defined: first_idx = lowest r with tags[r]=1, 0 when hit=0.
REQ-035 Macro undefined: priority encoder not built, first_idx tied to 0; all other behaviour identical.

Structure
REQ-036 Package ap_cam_pkg SHALL hold the opcode and tag-mode enumerations and the clog2 function.
REQ-037 One sub-module ap_cam_row (one WORD_SIZE register, masked-compare match output, masked write port) SHALL be instantiated CELL_QUANT times.

Verification (WORD_SIZE=8, CELL_QUANT=12)
REQ-038 WRITE rows 0..11 with 0x10+r, READ addr 5 -> rsp_valid 2 cycles after accept, rsp_data=0x15, rsp_err=0; cmd_ready low for 2 cycles.
REQ-039 SEARCH LOAD key=0x10 mask=0xF0 -> tags=0xFFF, match_cnt=12; then SEARCH AND key=0x01 mask=0x01 -> tags=0xAAA, match_cnt=6, first_idx=1 (0 without macro).
REQ-040 With tags=0xAAA, AP_WRITE data=0x0C mask=0x0F -> READ 3 returns 0x1C, READ 2 returns 0x12; then TAG_CLR, AP_WRITE -> READ 3 still returns 0x1C.
REQ-041 READ addr 13 -> rsp_err=1, rsp_data=0; WRITE addr 12 data 0xFF -> rsp_err=1, subsequent SEARCH key=0xFF mask=0xFF -> hit=0.
REQ-042 Accept WRITE addr 0 data 0xAA, assert rst during EXEC -> no rsp_valid, READ 0 after release returns 0x00, tags=0.
REQ-043 SEARCH mask=0x00 then OR mode with no matches -> tags=0xFFF persists, match_cnt=12.

Source files
------------

// File: rtl/ap_cam_pkg.sv
// Shared opcode/tag-mode/state enumerations and the width helper for the associative CAM engine.
package ap_cam_pkg;

    typedef enum logic [2:0] {
        OP_NOP      = 3'd0,
        OP_WRITE    = 3'd1,
        OP_READ     = 3'd2,
        OP_SEARCH   = 3'd3,
        OP_AP_WRITE = 3'd4,
        OP_TAG_CLR  = 3'd5,
        OP_TAG_SET  = 3'd6
    } op_e;

    typedef enum logic [1:0] {
        TM_LOAD = 2'd0,
        TM_AND  = 2'd1,
        TM_OR   = 2'd2
    } tmode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RESP
    } state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        int unsigned rem;
        res = 0;
        rem = (value > 0) ? value - 1 : 0;
        while (rem > 0) begin
            rem = rem >> 1;
            res = res + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/ap_cam_row.sv
// One CAM row: a single word register with a masked-compare match and a bit-masked write port.
module ap_cam_row
    import ap_cam_pkg::*;
#(
    parameter int unsigned WORD_SIZE = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 we_i,
    input  logic [WORD_SIZE-1:0] wdata_i,
    input  logic [WORD_SIZE-1:0] wmask_i,
    input  logic [WORD_SIZE-1:0] key_i,
    input  logic [WORD_SIZE-1:0] cmask_i,
    output logic                 match_o,
    output logic [WORD_SIZE-1:0] word_o
);

    logic [WORD_SIZE-1:0] word_q;
    logic [WORD_SIZE-1:0] word_d;

    always_comb begin
        word_d = word_q;
        if (we_i) begin
            word_d = (word_q & ~wmask_i) | (wdata_i & wmask_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

    assign match_o = (((word_q ^ key_i) & cmask_i) == '0);
    assign word_o  = word_q;

endmodule

// File: rtl/ap_cam_engine.sv
// Associative-processing CAM engine: IDLE -> EXEC -> RESP command pipeline over CELL_QUANT rows.
// Define AP_CAM_PRIO_ENC_EN to build the lowest-set-tag priority encoder driving first_idx.
module ap_cam_engine
    import ap_cam_pkg::*;
#(
    parameter  int unsigned WORD_SIZE  = 8,
    parameter  int unsigned CELL_QUANT = 512,
    localparam int unsigned ADDR_W     = clog2(CELL_QUANT),
    localparam int unsigned CNT_W      = clog2(CELL_QUANT + 1)
) (
    input  logic                  CLK100MHZ,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_op,
    input  logic [1:0]            cmd_tmode,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [WORD_SIZE-1:0]  cmd_data,
    input  logic [WORD_SIZE-1:0]  cmd_mask,
    output logic                  rsp_valid,
    output logic                  rsp_err,
    output logic [WORD_SIZE-1:0]  rsp_data,
    output logic [CELL_QUANT-1:0] tags,
    output logic                  hit,
    output logic [CNT_W-1:0]      match_cnt,
    output logic [ADDR_W-1:0]     first_idx
);

    state_e                state_q, state_d;
    logic [2:0]            op_q;
    logic [1:0]            tmode_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [WORD_SIZE-1:0]  data_q;
    logic [WORD_SIZE-1:0]  mask_q;
    logic [CELL_QUANT-1:0] tags_q, tags_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [WORD_SIZE-1:0]  rsp_data_q, rsp_data_d;

    logic                  accept;
    logic                  addr_ok;
    logic [CELL_QUANT-1:0] row_match;
    logic [CELL_QUANT-1:0] row_we;
    logic [WORD_SIZE-1:0]  row_wmask;
    logic [WORD_SIZE-1:0]  row_val [CELL_QUANT];
    logic [WORD_SIZE-1:0]  rd_word;

    assign cmd_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign accept    = cmd_valid && cmd_ready;
    assign addr_ok   = (32'(addr_q) < CELL_QUANT);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Addressed row lookup by compare so an out-of-range address selects nothing.
    always_comb begin
        rd_word = '0;
        for (int unsigned r = 0; r < CELL_QUANT; r++) begin
            if (addr_q == ADDR_W'(r)) rd_word = row_val[r];
        end
    end

    always_comb begin
        tags_d     = tags_q;
        rsp_err_d  = rsp_err_q;
        rsp_data_d = rsp_data_q;
        row_we     = '0;
        row_wmask  = '1;
        if (state_q == ST_EXEC) begin
            rsp_err_d  = 1'b0;
            rsp_data_d = '0;
            case (op_q)
                OP_WRITE: begin
                    if (addr_ok) begin
                        for (int unsigned r = 0; r < CELL_QUANT; r++) begin
                            row_we[r] = (addr_q == ADDR_W'(r));
                        end
                    end else begin
                        rsp_err_d = 1'b1;
                    end
                end
                OP_READ: begin
                    if (addr_ok) rsp_data_d = rd_word;
                    else         rsp_err_d  = 1'b1;
                end
                OP_SEARCH: begin
                    case (tmode_q)
                        TM_AND:  tags_d = tags_q & row_match;
                        TM_OR:   tags_d = tags_q | row_match;
                        default: tags_d = row_match;
                    endcase
                end
                OP_AP_WRITE: begin
                    row_we    = tags_q;
                    row_wmask = mask_q;
                end
                OP_TAG_CLR: tags_d = '0;
                OP_TAG_SET: tags_d = '1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK100MHZ or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            tmode_q    <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            mask_q     <= '0;
            tags_q     <= '0;
            rsp_err_q  <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            tags_q     <= tags_d;
            rsp_err_q  <= rsp_err_d;
            rsp_data_q <= rsp_data_d;
            if (accept) begin
                op_q    <= cmd_op;
                tmode_q <= cmd_tmode;
                addr_q  <= cmd_addr;
                data_q  <= cmd_data;
                mask_q  <= cmd_mask;
            end
        end
    end

    for (genvar g = 0; g < CELL_QUANT; g++) begin : g_row
        ap_cam_row #(
            .WORD_SIZE(WORD_SIZE)
        ) u_row (
            .clk_i   (CLK100MHZ),
            .rst_ni  (rst),
            .we_i    (row_we[g]),
            .wdata_i (data_q),
            .wmask_i (row_wmask),
            .key_i   (data_q),
            .cmask_i (mask_q),
            .match_o (row_match[g]),
            .word_o  (row_val[g])
        );
    end

    always_comb begin
        match_cnt = '0;
        for (int unsigned r = 0; r < CELL_QUANT; r++) begin
            match_cnt = match_cnt + CNT_W'(tags_q[r]);
        end
    end

`ifdef AP_CAM_PRIO_ENC_EN
    always_comb begin
        logic found;
        found     = 1'b0;
        first_idx = '0;
        for (int unsigned r = 0; r < CELL_QUANT; r++) begin
            if (tags_q[r] && !found) begin
                first_idx = ADDR_W'(r);
                found     = 1'b1;
            end
        end
    end
`else
    assign first_idx = '0;
`endif

    assign tags     = tags_q;
    assign hit      = |tags_q;
    assign rsp_err  = rsp_err_q;
    assign rsp_data = rsp_data_q;

endmodule
